// File: rtl/chess_pkg.sv
// Shared definitions for the board-coordinate datapath: default coordinate
// width, arbitration mode encodings and the packed-channel slice helper.
package chess_pkg;

    localparam int   COORD_W_DEFAULT = 3;
    localparam logic MODO_FIXO       = 1'b0;
    localparam logic MODO_RR         = 1'b1;

    // LSB position of channel ch inside a bus packing channels of width w
    function automatic int coord_lsb(input int ch, input int w);
        return ch * w;
    endfunction

endpackage

// File: rtl/arbitro_rr.sv
// Combinational round-robin picker: the first requester strictly after ptr,
// wrapping modulo N_GEN, wins.
module arbitro_rr #(
    parameter  int N_GEN = 2,
    localparam int ID_W  = $clog2(N_GEN)
) (
    input  logic [N_GEN-1:0] req,
    input  logic [ID_W-1:0]  ptr,
    output logic [N_GEN-1:0] grant_onehot,
    output logic [ID_W-1:0]  grant_idx,
    output logic             any
);

    int idx;

    always_comb begin
        grant_onehot = '0;
        grant_idx    = '0;
        any          = 1'b0;
        idx          = 0;
        for (int k = 1; k <= N_GEN; k++) begin
            idx = (int'(ptr) + k) % N_GEN;
            if (!any && req[idx]) begin
                any               = 1'b1;
                grant_idx         = ID_W'(idx);
                grant_onehot[idx] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/seletor_gerador_rr.sv
// N-channel coordinate selector: picks one generator per load opportunity
// (fixed index or round-robin) into a one-entry registered output stage.
module seletor_gerador_rr
    import chess_pkg::*;
#(
    parameter  int N_GEN   = 2,
    parameter  int COORD_W = COORD_W_DEFAULT,
    localparam int ID_W    = $clog2(N_GEN)
) (
    input  logic                     clock,
    input  logic                     reset_n,
    input  logic                     modo,
    input  logic [ID_W-1:0]          sel_fixo,
    input  logic [N_GEN-1:0]         gen_valid,
    input  logic [N_GEN*COORD_W-1:0] gen_linha,
    input  logic [N_GEN*COORD_W-1:0] gen_coluna,
    output logic [N_GEN-1:0]         gen_ready,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [COORD_W-1:0]       linha,
    output logic [COORD_W-1:0]       coluna,
    output logic [ID_W-1:0]          out_gen_id
);

    logic               out_valid_q, out_valid_d;
    logic [COORD_W-1:0] linha_q, linha_d;
    logic [COORD_W-1:0] coluna_q, coluna_d;
    logic [ID_W-1:0]    id_q, id_d;
    logic [ID_W-1:0]    ptr_q, ptr_d;

    logic               load, fix_hit, cand, grant;
    logic [ID_W-1:0]    g_idx;
    logic [COORD_W-1:0] sel_linha, sel_coluna;
    logic [N_GEN-1:0]   arb_onehot;
    logic [ID_W-1:0]    arb_idx;
    logic               arb_any;

    arbitro_rr #(.N_GEN(N_GEN)) u_arb (
        .req          (gen_valid),
        .ptr          (ptr_q),
        .grant_onehot (arb_onehot),
        .grant_idx    (arb_idx),
        .any          (arb_any)
    );

    always_comb begin
        load       = !out_valid_q || out_ready;
        fix_hit    = 1'b0;
        sel_linha  = '0;
        sel_coluna = '0;
        gen_ready  = '0;

        // An out-of-range sel_fixo matches no channel, so it never grants
        for (int i = 0; i < N_GEN; i++) begin
            if (sel_fixo == ID_W'(i)) fix_hit = gen_valid[i];
        end

        if (modo == MODO_RR) begin
            cand  = arb_any;
            g_idx = arb_idx;
        end else begin
            cand  = fix_hit;
            g_idx = sel_fixo;
        end
        grant = load && cand;

        for (int i = 0; i < N_GEN; i++) begin
            if (g_idx == ID_W'(i)) begin
                sel_linha    = gen_linha[coord_lsb(i, COORD_W) +: COORD_W];
                sel_coluna   = gen_coluna[coord_lsb(i, COORD_W) +: COORD_W];
                gen_ready[i] = grant && reset_n;
            end
        end

        out_valid_d = out_valid_q;
        linha_d     = linha_q;
        coluna_d    = coluna_q;
        id_d        = id_q;
        ptr_d       = ptr_q;
        if (load) begin
            out_valid_d = grant;
            if (grant) begin
                linha_d  = sel_linha;
                coluna_d = sel_coluna;
                id_d     = g_idx;
                if (modo == MODO_RR) ptr_d = g_idx;
            end
        end
    end

    // Pointer resets to the last channel so the first search begins at 0
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            out_valid_q <= 1'b0;
            linha_q     <= '0;
            coluna_q    <= '0;
            id_q        <= '0;
            ptr_q       <= ID_W'(N_GEN - 1);
        end else begin
            out_valid_q <= out_valid_d;
            linha_q     <= linha_d;
            coluna_q    <= coluna_d;
            id_q        <= id_d;
            ptr_q       <= ptr_d;
        end
    end

    assign out_valid  = out_valid_q;
    assign linha      = linha_q;
    assign coluna     = coluna_q;
    assign out_gen_id = id_q;

endmodule
